// File: rtl/riscv_jp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_jp_pkg
// Purpose  : Shared types for the jump-predictor resolution tracker. This
//            package holds the in-flight prediction entry, the history/update
//            record sent back to the BTB, and a next-sequential-PC helper.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_jp_pkg;

    // The entry and history layouts are fixed at this PC width.
    localparam int JP_ADDR_WIDTH = 64;

    // One prediction made at fetch time, held until the instruction resolves.
    typedef struct packed {
        logic [JP_ADDR_WIDTH-1:0] pc;
        logic                     pred_taken;
        logic [JP_ADDR_WIDTH-1:0] pred_addr;
    } jp_entry_t;

    // Training record handed back to the BTB/counter strategy.
    typedef struct packed {
        logic [JP_ADDR_WIDTH-1:0] pc;
        logic [JP_ADDR_WIDTH-1:0] jump_addr;
        logic                     jump_branch;
        logic                     could_jump;
        logic                     flush;
    } jp_hist_t;

    // Sequential successor of a 4-byte instruction. The result wraps modulo
    // 2^JP_ADDR_WIDTH.
    function automatic logic [JP_ADDR_WIDTH-1:0] jp_next_pc(input logic [JP_ADDR_WIDTH-1:0] pc);
        return pc + JP_ADDR_WIDTH'(4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_next_strategy_resolve_tracker_if.sv
`default_nettype none
// ============================================================================
// Module   : riscv_next_strategy_resolve_tracker_if
// Purpose  : Bus between the IF/EX pipeline and the resolution tracker.
//            Ports:
//              i_push*   - prediction recorded by IF
//              i_res*    - resolution of the oldest in-flight instruction
//              o_redirect* - mispredict refetch request
//              o_hist*   - BTB training record
//              o_count/o_full/o_empty/o_error/o_mispredicts - status
//            Modports:
//              master - the pipeline side
//              slave  - the tracker
// Revision : 1.0 - initial release
// ============================================================================
interface riscv_next_strategy_resolve_tracker_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
);
    logic                     i_stall;
    logic                     i_push;
    logic [ADDR_WIDTH-1:0]    i_push_pc;
    logic                     i_push_pred_taken;
    logic [ADDR_WIDTH-1:0]    i_push_pred_addr;
    logic                     i_res_valid;
    logic                     i_res_flush;
    logic                     i_res_could_jump;
    logic                     i_res_taken;
    logic [ADDR_WIDTH-1:0]    i_res_target;

    logic                     o_redirect;
    logic [ADDR_WIDTH-1:0]    o_redirect_addr;
    logic                     o_hist_valid;
    logic [ADDR_WIDTH-1:0]    o_hist_pc;
    logic [ADDR_WIDTH-1:0]    o_hist_jump_addr;
    logic                     o_hist_jump_branch;
    logic                     o_hist_could_jump;
    logic                     o_hist_flush;
    logic [$clog2(DEPTH):0]   o_count;
    logic                     o_full;
    logic                     o_empty;
    logic                     o_error;
    logic [CNT_WIDTH-1:0]     o_mispredicts;

    modport master (
        output i_stall, i_push, i_push_pc, i_push_pred_taken, i_push_pred_addr,
        output i_res_valid, i_res_flush, i_res_could_jump, i_res_taken, i_res_target,
        input  o_redirect, o_redirect_addr, o_hist_valid, o_hist_pc, o_hist_jump_addr,
        input  o_hist_jump_branch, o_hist_could_jump, o_hist_flush,
        input  o_count, o_full, o_empty, o_error, o_mispredicts
    );

    modport slave (
        input  i_stall, i_push, i_push_pc, i_push_pred_taken, i_push_pred_addr,
        input  i_res_valid, i_res_flush, i_res_could_jump, i_res_taken, i_res_target,
        output o_redirect, o_redirect_addr, o_hist_valid, o_hist_pc, o_hist_jump_addr,
        output o_hist_jump_branch, o_hist_could_jump, o_hist_flush,
        output o_count, o_full, o_empty, o_error, o_mispredicts
    );
endinterface
`default_nettype wire

// File: rtl/riscv_jp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : riscv_jp_fifo
// Purpose  : In-order queue of DEPTH entries with a single-cycle flush.
//            The pointers carry one extra wrap bit, so the queue can tell
//            full from empty. The caller qualifies push and pop: a push must
//            not target a full queue unless a pop happens in the same cycle,
//            and a pop must not target an empty queue. Flush wins over push
//            and pop.
//            Ports:
//              clk, rst                   - clock, synchronous active-high reset
//              i_flush                    - empty the queue
//              i_push, i_push_data        - enqueue
//              i_pop, o_pop_data          - dequeue; the head is always visible
//              o_count, o_full, o_empty   - occupancy
// Revision : 1.0 - initial release
// ============================================================================
module riscv_jp_fifo #(
    parameter int DATA_WIDTH = 129,
    parameter int DEPTH      = 4
) (
    input  wire logic                    clk,
    input  wire logic                    rst,
    input  wire logic                    i_flush,
    input  wire logic                    i_push,
    input  wire logic [DATA_WIDTH-1:0]   i_push_data,
    input  wire logic                    i_pop,
    output logic      [DATA_WIDTH-1:0]   o_pop_data,
    output logic      [$clog2(DEPTH):0]  o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      w_count;

    // With a power-of-two DEPTH, the modular pointer difference is the occupancy.
    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign o_count    = w_count;
    assign o_full     = (w_count == PTR_W'(DEPTH));
    assign o_empty    = (w_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr[IDX_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
        end
    end

    // Reset does not clear the storage. An entry is only read after a push
    // has written it.
    always_ff @(posedge clk) begin
        if (i_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/riscv_next_strategy_resolve_tracker.sv
`default_nettype none
// ============================================================================
// Module   : riscv_next_strategy_resolve_tracker
// Purpose  : Resolution end of the BTB-counter jump predictor. The module
//            queues every fetch-side prediction in order. When the oldest
//            instruction resolves in EX, the module pops its entry and checks
//            the prediction against the actual outcome. One cycle later it
//            emits a registered BTB training record and, on a mispredict, a
//            redirect.
//            Ports:
//              clk, reset, enable - clock, synchronous active-high reset,
//                                   tracker enable
//              bus (slave)        - push/resolve inputs, redirect/history
//                                   outputs and status
// Revision : 1.0 - initial release
// ============================================================================
module riscv_next_strategy_resolve_tracker
    import riscv_jp_pkg::*;
#(
    parameter int ADDR_WIDTH = JP_ADDR_WIDTH,   // must equal JP_ADDR_WIDTH
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic enable,
    riscv_next_strategy_resolve_tracker_if.slave bus
);
    jp_entry_t              w_new_entry;
    jp_entry_t              w_head;
    logic [$clog2(DEPTH):0] w_count;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_active;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_taken;
    logic                   w_mispredict;
    logic                   w_fifo_flush;
    logic                   w_err;

    logic                   r_redirect;
    logic [ADDR_WIDTH-1:0]  r_redirect_addr;
    logic                   r_hist_valid;
    jp_hist_t               r_hist;
    logic                   r_error;
    logic [CNT_WIDTH-1:0]   r_mispredicts;

    assign w_new_entry.pc         = bus.i_push_pc;
    assign w_new_entry.pred_taken = bus.i_push_pred_taken;
    assign w_new_entry.pred_addr  = bus.i_push_pred_addr;

    assign w_active = enable && !bus.i_stall;
    assign w_pop    = w_active && bus.i_res_valid && !w_empty;

    // A non-jump instruction never counts as taken. A predicted-taken
    // non-jump is therefore a mispredict.
    assign w_taken      = bus.i_res_could_jump && bus.i_res_taken;
    assign w_mispredict = w_pop && !bus.i_res_flush &&
                          ((w_head.pred_taken != w_taken) ||
                           (w_taken && (w_head.pred_addr != bus.i_res_target)));

    // A pop in the same cycle frees a slot, so a push into a full queue is
    // legal then. On a mispredict the same-cycle push is on the wrong path
    // and is dropped.
    assign w_push = w_active && bus.i_push && (!w_full || w_pop) && !w_mispredict;

    // After a mispredict, everything younger than the popped entry is on the
    // wrong path.
    assign w_fifo_flush = !enable || w_mispredict;

    assign w_err = w_active &&
                   ((bus.i_res_valid && w_empty) || (bus.i_push && w_full && !w_pop));

    riscv_jp_fifo #(
        .DATA_WIDTH ($bits(jp_entry_t)),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (w_fifo_flush),
        .i_push      (w_push),
        .i_push_data (w_new_entry),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_redirect      <= 1'b0;
            r_redirect_addr <= '0;
            r_hist_valid    <= 1'b0;
            r_hist          <= '0;
            r_error         <= 1'b0;
            r_mispredicts   <= '0;
        end else begin
            // w_pop is already zero during a stall or while disabled, so
            // both pulses drop there too.
            r_redirect   <= w_mispredict;
            r_hist_valid <= w_pop;

            if (w_mispredict) begin
                r_redirect_addr <= w_taken ? bus.i_res_target : jp_next_pc(w_head.pc);
            end

            if (w_pop) begin
                r_hist.pc          <= w_head.pc;
                r_hist.jump_addr   <= bus.i_res_target;
                r_hist.jump_branch <= bus.i_res_taken;
                r_hist.could_jump  <= bus.i_res_could_jump;
                r_hist.flush       <= bus.i_res_flush;
            end

            if (w_err) begin
                r_error <= 1'b1;
            end

            if (w_mispredict && (r_mispredicts != '1)) begin
                r_mispredicts <= r_mispredicts + CNT_WIDTH'(1);
            end
        end
    end

    assign bus.o_redirect         = r_redirect;
    assign bus.o_redirect_addr    = r_redirect_addr;
    assign bus.o_hist_valid       = r_hist_valid;
    assign bus.o_hist_pc          = r_hist.pc;
    assign bus.o_hist_jump_addr   = r_hist.jump_addr;
    assign bus.o_hist_jump_branch = r_hist.jump_branch;
    assign bus.o_hist_could_jump  = r_hist.could_jump;
    assign bus.o_hist_flush       = r_hist.flush;
    assign bus.o_count            = w_count;
    assign bus.o_full             = w_full;
    assign bus.o_empty            = w_empty;
    assign bus.o_error            = r_error;
    assign bus.o_mispredicts      = r_mispredicts;

endmodule
`default_nettype wire

// File: tb/tb_riscv_next_strategy_resolve_tracker.sv
`default_nettype none
// ============================================================================
// Module   : tb_riscv_next_strategy_resolve_tracker
// Purpose  : Self-checking bench for the jump-predictor resolution tracker.
//            The bench runs directed scenarios and then random traffic. A
//            queue-based reference model supplies every expected value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_next_strategy_resolve_tracker;
    localparam int ADDR_WIDTH = 64;
    localparam int DEPTH      = 4;
    localparam int CNT_WIDTH  = 4;      // narrow, so saturation is reachable
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    logic clk;
    logic reset;
    logic enable;

    riscv_next_strategy_resolve_tracker_if #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) bus ();

    riscv_next_strategy_resolve_tracker #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH),
        .CNT_WIDTH  (CNT_WIDTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [63:0] pc;
        bit          pt;
        logic [63:0] pa;
    } ent_t;

    ent_t        m_q[$];
    bit          m_redirect;
    logic [63:0] m_raddr;
    bit          m_hv;
    logic [63:0] m_hpc;
    logic [63:0] m_hja;
    bit          m_hjb;
    bit          m_hcj;
    bit          m_hfl;
    bit          m_err;
    int          m_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply the prediction rules to the inputs that are about to be clocked in.
    task automatic model_update();
        ent_t e;
        bit   mis;
        bit   tk;
        if (reset) begin
            m_q.delete();
            m_redirect = 0; m_raddr = 0; m_hv = 0;
            m_hpc = 0; m_hja = 0; m_hjb = 0; m_hcj = 0; m_hfl = 0;
            m_err = 0; m_cnt = 0;
        end else if (!enable) begin
            m_q.delete();
            m_redirect = 0;
            m_hv = 0;
        end else if (bus.i_stall) begin
            m_redirect = 0;
            m_hv = 0;
        end else begin
            m_redirect = 0;
            m_hv = 0;
            mis = 0;
            if (bus.i_res_valid) begin
                if (m_q.size() == 0) begin
                    m_err = 1;
                end else begin
                    e = m_q.pop_front();
                    m_hv  = 1;
                    m_hpc = e.pc;
                    m_hja = bus.i_res_target;
                    m_hjb = bus.i_res_taken;
                    m_hcj = bus.i_res_could_jump;
                    m_hfl = bus.i_res_flush;
                    if (!bus.i_res_flush) begin
                        tk = bus.i_res_could_jump && bus.i_res_taken;
                        if ((e.pt != tk) || (tk && (e.pa != bus.i_res_target))) begin
                            mis = 1;
                            m_redirect = 1;
                            m_raddr = tk ? bus.i_res_target : e.pc + 64'd4;
                            if (m_cnt < CNT_MAX) m_cnt++;
                        end
                    end
                end
            end
            if (bus.i_push && !mis) begin
                if (m_q.size() < DEPTH) begin
                    e.pc = bus.i_push_pc;
                    e.pt = bus.i_push_pred_taken;
                    e.pa = bus.i_push_pred_addr;
                    m_q.push_back(e);
                end else begin
                    m_err = 1;
                end
            end
            if (mis) m_q.delete();
        end
    endtask

    task automatic compare_all();
        check_eq("redirect", bus.o_redirect, m_redirect);
        if (m_redirect) check_eq("redirect_addr", bus.o_redirect_addr, m_raddr);
        check_eq("hist_valid", bus.o_hist_valid, m_hv);
        if (m_hv) begin
            check_eq("hist_pc", bus.o_hist_pc, m_hpc);
            check_eq("hist_jump_addr", bus.o_hist_jump_addr, m_hja);
            check_eq("hist_jump_branch", bus.o_hist_jump_branch, m_hjb);
            check_eq("hist_could_jump", bus.o_hist_could_jump, m_hcj);
            check_eq("hist_flush", bus.o_hist_flush, m_hfl);
        end
        check_eq("count", bus.o_count, m_q.size());
        check_eq("full", bus.o_full, m_q.size() == DEPTH);
        check_eq("empty", bus.o_empty, m_q.size() == 0);
        check_eq("error", bus.o_error, m_err);
        check_eq("mispredicts", bus.o_mispredicts, m_cnt);
    endtask

    // Drive one cycle of stimulus, advance the model, clock and compare.
    task automatic drive(input bit rst, input bit en, input bit st,
                         input bit ps, input logic [63:0] pc, input bit pt, input logic [63:0] pa,
                         input bit rv, input bit fl, input bit cj, input bit tk,
                         input logic [63:0] tgt);
        reset                 = rst;
        enable                = en;
        bus.i_stall           = st;
        bus.i_push            = ps;
        bus.i_push_pc         = pc;
        bus.i_push_pred_taken = pt;
        bus.i_push_pred_addr  = pa;
        bus.i_res_valid       = rv;
        bus.i_res_flush       = fl;
        bus.i_res_could_jump  = cj;
        bus.i_res_taken       = tk;
        bus.i_res_target      = tgt;
        model_update();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [63:0] pc, input bit pt, input logic [63:0] pa);
        drive(0, 1, 0, 1, pc, pt, pa, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input bit cj, input bit tk, input logic [63:0] tgt);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 0, cj, tk, tgt);
    endtask

    logic [63:0] r_pc;
    logic [63:0] r_pa;
    logic [63:0] r_tgt;

    initial begin
        do_reset();
        check_eq("rst_empty", bus.o_empty, 1);
        check_eq("rst_redirect", bus.o_redirect, 0);
        check_eq("rst_count", bus.o_count, 0);

        // 1: correctly predicted not-taken
        push(64'h100, 0, 0);
        resolve(1, 0, 64'h104);
        check_eq("t1_redirect", bus.o_redirect, 0);
        check_eq("t1_hist_valid", bus.o_hist_valid, 1);
        check_eq("t1_hist_pc", bus.o_hist_pc, 64'h100);
        check_eq("t1_empty", bus.o_empty, 1);

        // 2: taken with the wrong target
        push(64'h200, 1, 64'h400);
        resolve(1, 1, 64'h480);
        check_eq("t2_redirect", bus.o_redirect, 1);
        check_eq("t2_addr", bus.o_redirect_addr, 64'h480);
        check_eq("t2_mispredicts", bus.o_mispredicts, 1);

        // 3: predicted taken, not taken; the same-cycle push is dropped
        push(64'h300, 1, 64'h380);
        drive(0, 1, 0, 1, 64'h304, 0, 0, 1, 0, 1, 0, 64'h380);
        check_eq("t3_addr", bus.o_redirect_addr, 64'h304);
        check_eq("t3_count", bus.o_count, 0);

        // 4: fill, then push+pop while full, then overflow
        do_reset();
        for (int i = 0; i < DEPTH; i++) push(64'h1000 + 64'(i * 4), 0, 0);
        check_eq("t4_full", bus.o_full, 1);
        drive(0, 1, 0, 1, 64'h2000, 0, 0, 1, 0, 0, 0, 0);
        check_eq("t4_count", bus.o_count, 4);
        check_eq("t4_no_error", bus.o_error, 0);
        push(64'h3000, 0, 0);
        check_eq("t4_error", bus.o_error, 1);
        check_eq("t4_count_hold", bus.o_count, 4);

        // 5: flushed resolve, then a stalled resolve
        do_reset();
        push(64'h500, 1, 64'h900);
        drive(0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        check_eq("t5_hist_flush", bus.o_hist_flush, 1);
        check_eq("t5_no_redirect", bus.o_redirect, 0);
        push(64'h600, 0, 0);
        drive(0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0);
        check_eq("t5_stall_hv", bus.o_hist_valid, 0);
        check_eq("t5_stall_count", bus.o_count, 1);
        resolve(1, 0, 0);

        // 6: PC wrap on the fall-through address
        push(64'hFFFF_FFFF_FFFF_FFFC, 1, 64'h40);
        resolve(1, 0, 64'h40);
        check_eq("t6_redirect", bus.o_redirect, 1);
        check_eq("t6_addr", bus.o_redirect_addr, 64'h0);

        // enable low clears the queue
        push(64'h700, 0, 0);
        push(64'h704, 0, 0);
        drive(0, 0, 0, 1, 64'h708, 0, 0, 0, 0, 0, 0, 0);
        check_eq("en_clear", bus.o_count, 0);

        // random traffic
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            r_pc = {$urandom(), $urandom()};
            r_pc[1:0] = 2'b00;
            if ($urandom_range(0, 19) == 0) r_pc = 64'hFFFF_FFFF_FFFF_FFFC;
            r_pa  = $urandom_range(0, 1) ? 64'h1000 : 64'h2000;
            r_tgt = $urandom_range(0, 1) ? 64'h1000 : 64'h2000;
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 29) != 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 1) == 1, r_pc, 1'($urandom_range(0, 1)), r_pa,
                  $urandom_range(0, 9) < 4,
                  $urandom_range(0, 6) == 0,
                  $urandom_range(0, 9) < 7,
                  1'($urandom_range(0, 1)), r_tgt);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
